fpu_int_normalise: RTL



---
 rtl/fpu_norm_pkg.sv | 22 ++
 rtl/fpu_lzc.sv | 23 ++
 rtl/fpu_int_normalise.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fpu_norm_pkg.sv
// Shared types and helpers for the integer-to-float normalisation front end.
package fpu_norm_pkg;

    localparam int unsigned MaxWidth = 64;

    function automatic int unsigned lzc_w(int unsigned width);
        return $clog2(width + 1);
    endfunction

    localparam int unsigned MaxLzcW = lzc_w(MaxWidth);

    // Sized for the widest build; narrower builds use the low bits of lzc/mant.
    typedef struct packed {
        logic                sign;
        logic                zero;
        logic [MaxLzcW-1:0]  lzc;
        logic [MaxWidth-1:0] mant;
        logic                guard;
        logic                sticky;
    } norm_res_t;

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fpu_lzc
    import fpu_norm_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0]        data_i,
    output logic [lzc_w(WIDTH)-1:0] cnt_o
);

    localparam int unsigned LzcW = lzc_w(WIDTH);

    // Ascending scan: the highest set bit is the last to write the count.
    always_comb begin
        cnt_o = LzcW'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                cnt_o = LzcW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu_int_normalise.sv
// Two-stage integer-to-float normalisation front end (sign/magnitude, then LZC/shift).
// Define FPU_NORM_STICKY_EN to build the guard/sticky outputs; otherwise they read 0.
module fpu_int_normalise
    import fpu_norm_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned MANT_W = 53
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_signed,
    input  logic                    in_word32,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sign,
    output logic                    out_zero,
    output logic [lzc_w(WIDTH)-1:0] out_lzc,
    output logic [MANT_W-1:0]       out_mant,
    output logic                    out_guard,
    output logic                    out_sticky
);

    localparam int unsigned LzcW = lzc_w(WIDTH);

    if (!(WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
        $error("fpu_int_normalise: WIDTH must be 32 or 64");
    end
    if (MANT_W < 2 || MANT_W > WIDTH - 2) begin : g_bad_mant
        $error("fpu_int_normalise: MANT_W must lie in 2..WIDTH-2");
    end

    logic [WIDTH-1:0] opnd;

    if (WIDTH > 32) begin : g_ext
        assign opnd = in_word32 ? {{(WIDTH-32){in_signed & in_data[31]}}, in_data[31:0]}
                                : in_data;
    end else begin : g_noext
        logic unused_word32;
        assign opnd          = in_data;
        assign unused_word32 = in_word32;
    end

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q, s1_sign_d;
    logic [WIDTH-1:0] s1_mag_q, s1_mag_d;
    logic             s2_valid_q, s2_valid_d;
    norm_res_t        s2_q, s2_d;

    logic s2_en, in_fire, s2_load;

    assign s2_en    = !s2_valid_q || out_ready;
    assign in_ready = !flush && (!s1_valid_q || s2_en);
    assign in_fire  = in_valid && in_ready;
    assign s2_load  = !flush && s2_en && s1_valid_q;

    always_comb begin
        s1_sign_d = s1_sign_q;
        s1_mag_d  = s1_mag_q;
        if (in_fire) begin
            s1_sign_d = in_signed & opnd[WIDTH-1];
            s1_mag_d  = s1_sign_d ? ('0 - opnd) : opnd;
        end
    end

    always_comb begin
        s1_valid_d = 1'b0;
        s2_valid_d = 1'b0;
        if (!flush) begin
            s1_valid_d = in_fire || (s1_valid_q && !s2_en);
            s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
        end
    end

    logic [LzcW-1:0]  lzc;
    logic [WIDTH-1:0] norm;

    fpu_lzc #(
        .WIDTH(WIDTH)
    ) u_lzc (
        .data_i(s1_mag_q),
        .cnt_o (lzc)
    );

    // A zero magnitude has lzc == WIDTH, which shifts everything out.
    assign norm = s1_mag_q << lzc;

    always_comb begin
        s2_d = s2_q;
        if (s2_load) begin
            s2_d                  = '0;
            s2_d.sign             = s1_sign_q;
            s2_d.zero             = (s1_mag_q == '0);
            s2_d.lzc[LzcW-1:0]    = lzc;
            s2_d.mant[MANT_W-1:0] = norm[WIDTH-1 -: MANT_W];
`ifdef FPU_NORM_STICKY_EN
            s2_d.guard            = norm[WIDTH-MANT_W-1];
            s2_d.sticky           = |norm[WIDTH-MANT_W-2:0];
`endif
        end
    end

`ifndef FPU_NORM_STICKY_EN
    logic unused_norm;
    assign unused_norm = ^norm[WIDTH-MANT_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
        end
    end

    logic unused_s2;
    assign unused_s2 = ^{s2_q.lzc, s2_q.mant};

    assign out_valid  = s2_valid_q;
    assign out_sign   = s2_q.sign;
    assign out_zero   = s2_q.zero;
    assign out_lzc    = s2_q.lzc[LzcW-1:0];
    assign out_mant   = s2_q.mant[MANT_W-1:0];
    assign out_guard  = s2_q.guard;
    assign out_sticky = s2_q.sticky;

endmodule
